datapath: RTL and testbench
===========================

# datapath

32-bit SRC-style processor datapath: sixteen general registers, PC, IR, MAR/MDR, HI/LO, Y/Z, ALU, internal 512×32 RAM, select-and-encode logic and a shared 32-bit bus. All transfers are driven cycle by cycle by external control strobes from the control-unit FSM. The block exports register and bus views for simulation.

## Interface
- MEM_INIT_FILE, "", hex file loaded into RAM at time 0 by $readmemh; empty means RAM starts at 0
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- R_rd_diog / R_wrt_diog  in  16  direct one-hot register load / drive enables
- Rin, R_out, BAout  in  1  S&E-decoded register load / drive / base-address drive
- Gra, Grb, Grc  in  1  S&E field select (IR Ra / Rb / Rc)
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1  bus drive selects
- MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd  in  1  register loads from the bus; Zlo_rd loads Zhi and Zlo together
- IncPC, Read, Write  in  1  ALU +1 override / MDR-from-RAM select / RAM write
- op_sel  in  5  ALU operation
- in_port  in  32  input-port data; tie to 0 when unused
- r2_view, r4_view, r6_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view  out  32  register contents
- MAR_view  out  9  MAR contents
- BusMuxOut  out  32  current bus value
- regControl_view  out  32  {16-bit register drive one-hot, 16-bit register load one-hot}

## Operation
- Bus: combinational one-hot mux, fixed priority R(Rn) > BAout > HI > LO > Zhi > Zlo > PC > MDR > MAR(zero-extended) > In > C. No select active gives bus = 0.
- S&E: IR fields Ra = [26:23], Rb = [22:19], Rc = [18:15], C = sign-extended [18:0].
- Index = OR of Gra/Grb/Grc-gated fields, decoded one-hot.
- Load enable: R_wrt_diog | (decode & Rin). Drive enable: R_rd_diog | (decode & (R_out | BAout)).
- With BAout, R0 drives 0.
- ALU: A = Y, B = bus, 64-bit result into Zhi:Zlo. op_sel codes:
  - 00011 ADD, 00100 SUB, 00101 AND, 00110 OR
  - 00111 SHR, 01000 SHRA, 01001 SHL, 01010 ROR, 01011 ROL (shift amount B[4:0])
  - 10001 NEG B, 10010 NOT B
  - 01111 MUL signed 64-bit; 10000 DIV: Zlo = quotient, Zhi = remainder
  - any other code gives 0
  - Zhi = 0 except MUL/DIV. Arithmetic wraps mod 2^32.
- IncPC overrides op_sel: result = bus + 1.
- MDR input = RAM[MAR] when Read is high, else the bus.
- Write: RAM[MAR] <= MDR on the rising edge.
- Asynchronous reset clears every register including R0–R15, PC, IR, MAR, MDR, Y, Z, HI and LO. All views read 0 during reset. RAM is not cleared.

## Timing
- All register loads and RAM writes occur on the rising edge of clk while the enable is high.
- Bus, ALU and RAM read paths are combinational: a load of bus or RAM data completes in 1 cycle.
- MAR loads bus[8:0].
- Simultaneous load and drive of the same register in one cycle loads the old value through the bus, with no loop.
- clr asserted mid-transfer aborts the transfer; the pending edge is ignored.

## Configuration
- DATAPATH_MULDIV_EN: defined means MUL/DIV are implemented as above.
- Undefined means codes 01111 and 10000 produce 0 and no multiplier or divider is synthesized.

## Structure
- Shared package `datapath_pkg` holds op_sel codes, IR field bit positions, RAM depth (512) and the bus select priority order.
- The one natural sub-module is `datapath_alu`: combinational, with inputs (a, b, op, inc) and a 64-bit output. Registers, bus, S&E logic and RAM stay at top level.

## Test plan
- Reset: drive clr low mid-cycle -> all views 0 immediately; BusMuxOut 0.
- Load R2 from RAM: RAM[0] = 0x78, drive PC_out + MAR_rd, then Read + MDR_rd, then MDR_out + R_wrt_diog[2] -> r2_view = 0x78.
- Fetch with RAM[2] = 0x03100063 and PC = 2:
  - PC_out + MAR_rd + Zlo_rd + IncPC, then Zlo_out + PC_rd + Read + MDR_rd, then MDR_out + IR_rd
  - required result: PC_view = 3, IR_view = 0x03100063.
- ld R6,0x63(R2) with RAM[0xDB] = 0x46:
  - Grb + BAout + Y_rd -> Y = 0x78
  - C_out + op_sel 00011 + Zlo_rd -> Zlo = 0xDB
  - Zlo_out + MAR_rd -> MAR = 0xDB
  - Read + MDR_rd -> MDR = 0x46
  - MDR_out + Gra + Rin -> r6_view = 0x46
- BAout with Rb = 0 while R0 = 5 -> BusMuxOut = 0.
- MUL with macro defined, Y = 0xFFFFFFFF, bus = 2 -> Zhi:Zlo = 0xFFFFFFFF_FFFFFFFE. With the macro undefined -> result 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the SRC-style datapath: ALU op codes, IR field
// positions, RAM geometry and the bus source priority order.
package datapath_pkg;

    localparam int RAM_DEPTH = 512;
    localparam int MAR_W     = 9;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;

    // Listed highest priority first; BAout always selects a register, so it
    // shares the BUS_REG slot.
    typedef enum logic [3:0] {
        BUS_NONE, BUS_REG, BUS_HI, BUS_LO, BUS_ZHI, BUS_ZLO,
        BUS_PC, BUS_MDR, BUS_MAR, BUS_IN, BUS_C
    } bus_src_e;

    function automatic logic [3:0] ir_field(input logic [31:0] ir, input int lsb);
        return ir[lsb +: 4];
    endfunction

    function automatic logic [31:0] ir_c_ext(input logic [31:0] ir);
        return {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit result for Zhi:Zlo.
// MUL/DIV exist only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  op,
    input  logic        inc,
    output logic [63:0] result
);

    logic [4:0]  shamt_s;
    logic [63:0] ror_s;
    logic [63:0] rol_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [63:0] prod_s;

    // Rotates via a doubled operand so a zero shift needs no special case
    always_comb begin
        shamt_s = b[4:0];
        ror_s   = {a, a} >> shamt_s;
        rol_s   = {a, a} << shamt_s;
    end

`ifdef DATAPATH_MULDIV_EN
    // Signed multiply/divide; divide by zero yields 0 and INT_MIN/-1 wraps
    always_comb begin
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        if (b == 32'd0) begin
            quot_s = 32'd0;
            rem_s  = 32'd0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quot_s = a;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(a) / $signed(b);
            rem_s  = $signed(a) % $signed(b);
        end
    end
`else
    // Multiplier and divider absent in this build
    always_comb begin
        prod_s = 64'd0;
        quot_s = 32'd0;
        rem_s  = 32'd0;
    end
`endif

    // Operation select; IncPC overrides op
    always_comb begin
        result = 64'd0;
        if (inc) begin
            result = {32'd0, b + 32'd1};
        end else begin
            case (op)
                OP_ADD:  result = {32'd0, a + b};
                OP_SUB:  result = {32'd0, a - b};
                OP_AND:  result = {32'd0, a & b};
                OP_OR:   result = {32'd0, a | b};
                OP_SHR:  result = {32'd0, a >> shamt_s};
                OP_SHRA: result = {32'd0, $signed(a) >>> shamt_s};
                OP_SHL:  result = {32'd0, a << shamt_s};
                OP_ROR:  result = {32'd0, ror_s[31:0]};
                OP_ROL:  result = {32'd0, rol_s[63:32]};
                OP_NEG:  result = {32'd0, 32'd0 - b};
                OP_NOT:  result = {32'd0, ~b};
                OP_MUL:  result = prod_s;
                OP_DIV:  result = {rem_s, quot_s};
                default: result = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// SRC-style datapath top: registers, shared bus, select-and-encode, RAM.
// DATAPATH_MULDIV_EN (in datapath_alu) enables MUL/DIV.
module datapath
    import datapath_pkg::*;
#(
    parameter string MEM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] R_rd_diog,
    input  logic [15:0] R_wrt_diog,
    input  logic        Rin,
    input  logic        R_out,
    input  logic        BAout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        Zhi_out,
    input  logic        Zlo_out,
    input  logic        PC_out,
    input  logic        MDR_out,
    input  logic        MAR_out,
    input  logic        In_out,
    input  logic        C_out,
    input  logic        MAR_rd,
    input  logic        Zlo_rd,
    input  logic        PC_rd,
    input  logic        MDR_rd,
    input  logic        IR_rd,
    input  logic        Y_rd,
    input  logic        HI_rd,
    input  logic        LO_rd,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic [4:0]  op_sel,
    input  logic [31:0] in_port,
    output logic [31:0] r2_view,
    output logic [31:0] r4_view,
    output logic [31:0] r6_view,
    output logic [31:0] Y_view,
    output logic [31:0] Zlo_view,
    output logic [31:0] MDR_view,
    output logic [31:0] PC_view,
    output logic [31:0] IR_view,
    output logic [8:0]  MAR_view,
    output logic [31:0] BusMuxOut,
    output logic [31:0] regControl_view
);

    logic [31:0]      r_r [16];
    logic [31:0]      pc_r, ir_r, mdr_r, hi_r, lo_r, y_r, zhi_r, zlo_r;
    logic [MAR_W-1:0] mar_r;
    logic [31:0]      ram_r [RAM_DEPTH];

    logic [3:0]  sel_idx_s;
    logic [15:0] dec_s, reg_load_s, reg_drive_s;
    logic [31:0] c_s, reg_val_s, bus_s, ram_rd_s;
    logic [63:0] alu_s;
    bus_src_e    bus_sel_s;

    // Select-and-encode: gated IR fields ORed into one register index
    always_comb begin
        sel_idx_s   = ({4{Gra}} & ir_field(ir_r, IR_RA_LSB))
                    | ({4{Grb}} & ir_field(ir_r, IR_RB_LSB))
                    | ({4{Grc}} & ir_field(ir_r, IR_RC_LSB));
        dec_s       = 16'd1 << sel_idx_s;
        reg_load_s  = R_wrt_diog | (dec_s & {16{Rin}});
        reg_drive_s = R_rd_diog | (dec_s & {16{R_out | BAout}});
        c_s         = ir_c_ext(ir_r);
    end

    // Driven register value; lowest index wins, R0 reads as 0 under BAout
    always_comb begin
        reg_val_s = 32'd0;
        for (int i = 15; i >= 1; i--) begin
            if (reg_drive_s[i]) begin
                reg_val_s = r_r[i];
            end else begin
                reg_val_s = reg_val_s;
            end
        end
        if (reg_drive_s[0]) begin
            reg_val_s = BAout ? 32'd0 : r_r[0];
        end else begin
            reg_val_s = reg_val_s;
        end
    end

    // Bus source priority encoder; bus is forced idle during reset
    always_comb begin
        bus_sel_s = BUS_NONE;
        if (!clr)              bus_sel_s = BUS_NONE;
        else if (|reg_drive_s) bus_sel_s = BUS_REG;
        else if (HI_out)       bus_sel_s = BUS_HI;
        else if (LO_out)       bus_sel_s = BUS_LO;
        else if (Zhi_out)      bus_sel_s = BUS_ZHI;
        else if (Zlo_out)      bus_sel_s = BUS_ZLO;
        else if (PC_out)       bus_sel_s = BUS_PC;
        else if (MDR_out)      bus_sel_s = BUS_MDR;
        else if (MAR_out)      bus_sel_s = BUS_MAR;
        else if (In_out)       bus_sel_s = BUS_IN;
        else if (C_out)        bus_sel_s = BUS_C;
        else                   bus_sel_s = BUS_NONE;
    end

    // Bus data mux
    always_comb begin
        bus_s = 32'd0;
        case (bus_sel_s)
            BUS_REG: bus_s = reg_val_s;
            BUS_HI:  bus_s = hi_r;
            BUS_LO:  bus_s = lo_r;
            BUS_ZHI: bus_s = zhi_r;
            BUS_ZLO: bus_s = zlo_r;
            BUS_PC:  bus_s = pc_r;
            BUS_MDR: bus_s = mdr_r;
            BUS_MAR: bus_s = {{(32 - MAR_W){1'b0}}, mar_r};
            BUS_IN:  bus_s = in_port;
            BUS_C:   bus_s = c_s;
            default: bus_s = 32'd0;
        endcase
    end

    datapath_alu u_alu (
        .a      (y_r),
        .b      (bus_s),
        .op     (op_sel),
        .inc    (IncPC),
        .result (alu_s)
    );

    assign ram_rd_s = ram_r[mar_r];

    // RAM write port; blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (Write && clr) begin
            ram_r[mar_r] <= mdr_r;
        end
    end

    // Architectural registers loaded from the bus, ALU or RAM
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) r_r[i] <= 32'd0;
            pc_r  <= 32'd0;
            ir_r  <= 32'd0;
            mar_r <= '0;
            mdr_r <= 32'd0;
            hi_r  <= 32'd0;
            lo_r  <= 32'd0;
            y_r   <= 32'd0;
            zhi_r <= 32'd0;
            zlo_r <= 32'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (reg_load_s[i]) r_r[i] <= bus_s;
            end
            if (PC_rd)  pc_r  <= bus_s;
            if (IR_rd)  ir_r  <= bus_s;
            if (MAR_rd) mar_r <= bus_s[MAR_W-1:0];
            if (MDR_rd) mdr_r <= Read ? ram_rd_s : bus_s;
            if (HI_rd)  hi_r  <= bus_s;
            if (LO_rd)  lo_r  <= bus_s;
            if (Y_rd)   y_r   <= bus_s;
            if (Zlo_rd) begin
                zhi_r <= alu_s[63:32];
                zlo_r <= alu_s[31:0];
            end
        end
    end

    assign r2_view         = r_r[2];
    assign r4_view         = r_r[4];
    assign r6_view         = r_r[6];
    assign Y_view          = y_r;
    assign Zlo_view        = zlo_r;
    assign MDR_view        = mdr_r;
    assign PC_view         = pc_r;
    assign IR_view         = ir_r;
    assign MAR_view        = mar_r;
    assign BusMuxOut       = bus_s;
    assign regControl_view = clr ? {reg_drive_s, reg_load_s} : 32'd0;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed SRC sequences plus randomized
// control strobes compared against a behavioural model every cycle.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] R_rd_diog, R_wrt_diog;
    logic        Rin, R_out, BAout, Gra, Grb, Grc;
    logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd;
    logic        IncPC, Read, Write;
    logic [4:0]  op_sel;
    logic [31:0] in_port;
    logic [31:0] r2_view, r4_view, r6_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view;
    logic [8:0]  MAR_view;
    logic [31:0] BusMuxOut, regControl_view;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mdr, m_hi, m_lo, m_y, m_zhi, m_zlo;
    logic [8:0]  m_mar;
    logic [31:0] m_ram [512];
    // Next-state staging
    logic [31:0] n_r [16];
    logic [31:0] n_pc, n_ir, n_mdr, n_hi, n_lo, n_y, n_zhi, n_zlo;
    logic [8:0]  n_mar;
    logic        n_wr;

    datapath dut (
        .clk(clk), .clr(clr), .R_rd_diog(R_rd_diog), .R_wrt_diog(R_wrt_diog),
        .Rin(Rin), .R_out(R_out), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out),
        .C_out(C_out), .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
        .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
        .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel), .in_port(in_port),
        .r2_view(r2_view), .r4_view(r4_view), .r6_view(r6_view), .Y_view(Y_view),
        .Zlo_view(Zlo_view), .MDR_view(MDR_view), .PC_view(PC_view), .IR_view(IR_view),
        .MAR_view(MAR_view), .BusMuxOut(BusMuxOut), .regControl_view(regControl_view)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_dec();
        int idx = 0;
        logic [15:0] one = 16'd1;
        if (Gra) idx = idx | int'(m_ir[26:23]);
        if (Grb) idx = idx | int'(m_ir[22:19]);
        if (Grc) idx = idx | int'(m_ir[18:15]);
        return one << idx;
    endfunction

    function automatic logic [15:0] m_drive();
        return R_rd_diog | (m_dec() & {16{R_out | BAout}});
    endfunction

    function automatic logic [15:0] m_load();
        return R_wrt_diog | (m_dec() & {16{Rin}});
    endfunction

    function automatic logic [31:0] m_bus();
        logic [15:0] drv = m_drive();
        if (!clr) return 32'd0;
        for (int i = 0; i < 16; i++)
            if (drv[i]) return (i == 0 && BAout) ? 32'd0 : m_r[i];
        if (HI_out)  return m_hi;
        if (LO_out)  return m_lo;
        if (Zhi_out) return m_zhi;
        if (Zlo_out) return m_zlo;
        if (PC_out)  return m_pc;
        if (MDR_out) return m_mdr;
        if (MAR_out) return {23'd0, m_mar};
        if (In_out)  return in_port;
        if (C_out)   return 32'($signed(m_ir[18:0]));
        return 32'd0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b);
        int s = int'(b[4:0]);
        logic [31:0] lo;
        int sa, sb;
        if (IncPC) return {32'd0, b + 32'd1};
        case (op_sel)
            5'd3:  lo = a + b;
            5'd4:  lo = a - b;
            5'd5:  lo = a & b;
            5'd6:  lo = a | b;
            5'd7:  lo = a >> s;
            5'd8:  lo = $signed(a) >>> s;
            5'd9:  lo = a << s;
            5'd10: lo = (a >> s) | (a << (32 - s));
            5'd11: lo = (a << s) | (a >> (32 - s));
            5'd17: lo = -b;
            5'd18: lo = ~b;
`ifdef DATAPATH_MULDIV_EN
            5'd15: return 64'(longint'($signed(a)) * longint'($signed(b)));
            5'd16: begin
                sa = $signed(a);
                sb = $signed(b);
                if (sb == 0) return 64'd0;
                if (a == 32'h8000_0000 && sb == -1) return {32'd0, a};
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            default: lo = 32'd0;
        endcase
        return {32'd0, lo};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
        m_pc = 0; m_ir = 0; m_mdr = 0; m_hi = 0; m_lo = 0;
        m_y = 0; m_zhi = 0; m_zlo = 0; m_mar = 0;
    endtask

    task automatic check_outputs();
        chk("bus", BusMuxOut, m_bus());
        chk("regctl", regControl_view, clr ? {m_drive(), m_load()} : 32'd0);
        chk("r2", r2_view, m_r[2]);
        chk("r4", r4_view, m_r[4]);
        chk("r6", r6_view, m_r[6]);
        chk("y", Y_view, m_y);
        chk("zlo", Zlo_view, m_zlo);
        chk("mdr", MDR_view, m_mdr);
        chk("pc", PC_view, m_pc);
        chk("ir", IR_view, m_ir);
        chk("mar", MAR_view, m_mar);
    endtask

    task automatic clear_ctrl();
        R_rd_diog = 16'd0; R_wrt_diog = 16'd0;
        {Rin, R_out, BAout, Gra, Grb, Grc} = 6'd0;
        {HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out} = 9'd0;
        {MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, HI_rd, LO_rd} = 8'd0;
        {IncPC, Read, Write} = 3'd0;
        op_sel = 5'd0;
        in_port = 32'd0;
    endtask

    // One clock: check settled outputs, predict the edge, then commit it
    task automatic cycle();
        logic [31:0] b;
        logic [15:0] ld;
        logic [63:0] z;
        #1;
        check_outputs();
        b  = m_bus();
        ld = m_load();
        z  = m_alu(m_y, b);
        for (int i = 0; i < 16; i++) n_r[i] = ld[i] ? b : m_r[i];
        n_pc  = PC_rd  ? b : m_pc;
        n_ir  = IR_rd  ? b : m_ir;
        n_mar = MAR_rd ? b[8:0] : m_mar;
        n_mdr = MDR_rd ? (Read ? m_ram[m_mar] : b) : m_mdr;
        n_hi  = HI_rd  ? b : m_hi;
        n_lo  = LO_rd  ? b : m_lo;
        n_y   = Y_rd   ? b : m_y;
        n_zhi = Zlo_rd ? z[63:32] : m_zhi;
        n_zlo = Zlo_rd ? z[31:0]  : m_zlo;
        n_wr  = Write;
        @(posedge clk);
        if (n_wr) m_ram[m_mar] = m_mdr;
        for (int i = 0; i < 16; i++) m_r[i] = n_r[i];
        m_pc = n_pc; m_ir = n_ir; m_mar = n_mar; m_mdr = n_mdr; m_hi = n_hi;
        m_lo = n_lo; m_y = n_y; m_zhi = n_zhi; m_zlo = n_zlo;
        @(negedge clk);
        clear_ctrl();
    endtask

    task automatic ram_write(input logic [8:0] addr, input logic [31:0] data);
        In_out = 1'b1; MAR_rd = 1'b1; in_port = {23'd0, addr}; cycle();
        In_out = 1'b1; MDR_rd = 1'b1; in_port = data; cycle();
        Write = 1'b1; cycle();
    endtask

    task automatic load_in(input logic [31:0] v, input int which);
        In_out = 1'b1; in_port = v;
        case (which)
            0: Y_rd = 1'b1;
            1: PC_rd = 1'b1;
            2: IR_rd = 1'b1;
            default: R_wrt_diog = 16'd1;
        endcase
        cycle();
    endtask

    // Asynchronous reset asserted mid-cycle with loads pending
    task automatic do_reset();
        In_out = 1'b1; in_port = $urandom | 32'h1; PC_rd = 1'b1; R_wrt_diog = 16'hFFFF; Zlo_rd = 1'b1;
        #2 clr = 1'b0;
        #1 m_reset();
        check_outputs();
        @(posedge clk);
        #1 check_outputs();
        @(negedge clk);
        clr = 1'b1;
        clear_ctrl();
    endtask

    function automatic logic rnd(input int n);
        return $urandom_range(0, n - 1) == 0;
    endfunction

    initial begin
        clear_ctrl();
        clr = 1'b0;
        m_reset();
        for (int a = 0; a < 512; a++) m_ram[a] = 32'd0;
        @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        clr = 1'b1;

        // Initialise every RAM word through the datapath itself
        for (int a = 0; a < 512; a++) ram_write(9'(a), $urandom);
        do_reset();

        ram_write(9'h000, 32'h0000_0078);
        ram_write(9'h002, 32'h0310_0063);
        ram_write(9'h0DB, 32'h0000_0046);
        load_in(32'd0, 1);

        // Load R2 from RAM[0]
        PC_out = 1'b1; MAR_rd = 1'b1; cycle();
        Read = 1'b1; MDR_rd = 1'b1; cycle();
        MDR_out = 1'b1; R_wrt_diog = 16'h0004; cycle();
        chk("lit_r2", r2_view, 32'h78);

        // Instruction fetch from address 2
        load_in(32'd2, 1);
        PC_out = 1'b1; MAR_rd = 1'b1; Zlo_rd = 1'b1; IncPC = 1'b1; cycle();
        Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1; cycle();
        MDR_out = 1'b1; IR_rd = 1'b1; cycle();
        chk("lit_fetch_pc", PC_view, 32'd3);
        chk("lit_fetch_ir", IR_view, 32'h0310_0063);

        // ld R6,0x63(R2)
        Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1; cycle();
        chk("lit_ld_y", Y_view, 32'h78);
        C_out = 1'b1; op_sel = 5'b00011; Zlo_rd = 1'b1; cycle();
        chk("lit_ld_zlo", Zlo_view, 32'hDB);
        Zlo_out = 1'b1; MAR_rd = 1'b1; cycle();
        chk("lit_ld_mar", MAR_view, 9'h0DB);
        Read = 1'b1; MDR_rd = 1'b1; cycle();
        chk("lit_ld_mdr", MDR_view, 32'h46);
        MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; cycle();
        chk("lit_ld_r6", r6_view, 32'h46);

        // BAout with Rb = 0 while R0 = 5
        load_in(32'd5, 3);
        load_in(32'd0, 2);
        Grb = 1'b1; BAout = 1'b1; #1 chk("lit_baout_r0", BusMuxOut, 32'd0); cycle();
        Grb = 1'b1; R_out = 1'b1; #1 chk("lit_rout_r0", BusMuxOut, 32'd5); cycle();

        // MUL -1 * 2
        load_in(32'hFFFF_FFFF, 0);
        In_out = 1'b1; in_port = 32'd2; op_sel = 5'b01111; Zlo_rd = 1'b1; cycle();
        Zhi_out = 1'b1;
`ifdef DATAPATH_MULDIV_EN
        chk("lit_mul_lo", Zlo_view, 32'hFFFF_FFFE);
        #1 chk("lit_mul_hi", BusMuxOut, 32'hFFFF_FFFF);
`else
        chk("lit_mul_lo", Zlo_view, 32'd0);
        #1 chk("lit_mul_hi", BusMuxOut, 32'd0);
`endif
        cycle();

        // DIV 7 / -2
        load_in(32'd7, 0);
        In_out = 1'b1; in_port = 32'hFFFF_FFFE; op_sel = 5'b10000; Zlo_rd = 1'b1; cycle();
        Zhi_out = 1'b1;
`ifdef DATAPATH_MULDIV_EN
        chk("lit_div_q", Zlo_view, 32'hFFFF_FFFD);
        #1 chk("lit_div_r", BusMuxOut, 32'd1);
`else
        chk("lit_div_q", Zlo_view, 32'd0);
        #1 chk("lit_div_r", BusMuxOut, 32'd0);
`endif
        cycle();

        // Shifts of 0x80000001 by 4
        load_in(32'h8000_0001, 0);
        In_out = 1'b1; in_port = 32'd4; op_sel = 5'b01000; Zlo_rd = 1'b1; cycle();
        chk("lit_shra", Zlo_view, 32'hF800_0000);
        In_out = 1'b1; in_port = 32'd4; op_sel = 5'b01010; Zlo_rd = 1'b1; cycle();
        chk("lit_ror", Zlo_view, 32'h1800_0000);

        // Randomized strobes against the model
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            if (rnd(2)) begin
                if (rnd(2)) R_rd_diog = 16'd1 << $urandom_range(0, 15);
            end else begin
                R_out = rnd(3);
                BAout = rnd(4);
            end
            {Gra, Grb, Grc} = 3'($urandom);
            Rin = rnd(4);
            R_wrt_diog = 16'($urandom & $urandom & $urandom);
            HI_out = rnd(8); LO_out = rnd(8); Zhi_out = rnd(8); Zlo_out = rnd(6);
            PC_out = rnd(6); MDR_out = rnd(6); MAR_out = rnd(8); In_out = rnd(3);
            C_out = rnd(4);
            MAR_rd = rnd(3); Zlo_rd = rnd(2); PC_rd = rnd(4); MDR_rd = rnd(3);
            IR_rd = rnd(5); Y_rd = rnd(3); HI_rd = rnd(4); LO_rd = rnd(4);
            IncPC = rnd(8); Read = rnd(2); Write = rnd(6);
            op_sel = 5'($urandom_range(0, 31));
            in_port = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
